// File: rtl/fir_stream_driver.sv
// fir_stream_driver
//   Host-side driver for a single-multiplier FIR filter. Takes one sample at a
//   time from a valid/ready input stream, launches one filter run for it, holds
//   the filter input stable for the whole run, and queues each result in a
//   show-ahead output FIFO. Runs that stall are aborted after TIMEOUT_CYC cycles
//   and reported on a sticky error flag.
// Ports
//   CLK, nRST            clock (posedge), asynchronous active-low reset
//   S_VALID/S_READY      input sample handshake, S_DATA sample
//   M_VALID/M_READY      output result handshake, M_DATA FIFO head
//   FIR_START            one-cycle start pulse to the filter
//   FIR_DIN              registered sample driven to the filter
//   FIR_DOUT, FIR_RDY    filter result and idle flag (high = idle)
//   CLR_ERR              clears TIMEOUT_ERR
//   TIMEOUT_ERR          sticky flag: a filter run was aborted
//   FIFO_LEVEL           number of results currently queued
module fir_stream_driver #(
  parameter int BIT_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          S_VALID,
  output logic                          S_READY,
  input  logic [BIT_WIDTH-1:0]          S_DATA,
  output logic                          M_VALID,
  input  logic                          M_READY,
  output logic [BIT_WIDTH-1:0]          M_DATA,
  output logic                          FIR_START,
  output logic [BIT_WIDTH-1:0]          FIR_DIN,
  input  logic [BIT_WIDTH-1:0]          FIR_DOUT,
  input  logic                          FIR_RDY,
  input  logic                          CLR_ERR,
  output logic                          TIMEOUT_ERR,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [LVL_W-1:0] LVL_ONE  = 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] din_q, din_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;

  logic s_ready;
  logic fifo_wr;
  logic fifo_rd;
  logic timeout;

  // Control FSM. The FIFO slot is reserved at accept time, so the WAIT_DONE
  // write can never overflow. The counter saturates at CNT_LAST so a late
  // WAIT_BUSY exit does not grant WAIT_DONE a fresh window.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    fifo_wr = 1'b0;
    timeout = 1'b0;
    s_ready = nRST && (state_q == IDLE) && FIR_RDY && (level_q < LVL_FULL);

    case (state_q)
      IDLE: begin
        if (S_VALID && s_ready) begin
          din_d   = S_DATA;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!FIR_RDY) begin
          state_d = WAIT_DONE;
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_DONE: begin
        if (FIR_RDY) begin
          fifo_wr = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      err_d = 1'b1;
    end else if (CLR_ERR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Output FIFO, show-ahead.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    fifo_rd  = (level_q != '0) && M_READY;

    if (fifo_wr) begin
      mem_d[wr_ptr_q] = FIR_DOUT;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({fifo_wr, fifo_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      din_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign S_READY     = s_ready;
  assign FIR_START   = (state_q == START);
  assign FIR_DIN     = din_q;
  assign M_VALID     = (level_q != '0);
  assign M_DATA      = mem_q[rd_ptr_q];
  assign TIMEOUT_ERR = err_q;
  assign FIFO_LEVEL  = level_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// tb_fir_stream_driver
//   Directed bench for fir_stream_driver with a behavioural filter: after a
//   start pulse the filter drops RDY for 10 cycles, then raises it with
//   DOUT = ~DIN. The filter can be frozen (never drops RDY) to force timeouts.
module tb_fir_stream_driver;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        S_VALID;
  logic        S_READY;
  logic [15:0] S_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic [15:0] M_DATA;
  logic        FIR_START;
  logic [15:0] FIR_DIN;
  logic [15:0] FIR_DOUT = '0;
  logic        FIR_RDY  = 1'b1;
  logic        CLR_ERR;
  logic        TIMEOUT_ERR;
  logic [2:0]  FIFO_LEVEL;

  fir_stream_driver #(
    .BIT_WIDTH  (16),
    .FIFO_DEPTH (4),
    .TIMEOUT_CYC(32)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .S_VALID    (S_VALID),
    .S_READY    (S_READY),
    .S_DATA     (S_DATA),
    .M_VALID    (M_VALID),
    .M_READY    (M_READY),
    .M_DATA     (M_DATA),
    .FIR_START  (FIR_START),
    .FIR_DIN    (FIR_DIN),
    .FIR_DOUT   (FIR_DOUT),
    .FIR_RDY    (FIR_RDY),
    .CLR_ERR    (CLR_ERR),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  // Filter model, evaluated on the falling edge.
  logic        model_stuck = 1'b0;
  int unsigned busy_left   = 0;
  int unsigned start_count = 0;
  logic [15:0] model_din   = '0;

  always @(negedge CLK) begin
    if (FIR_START) begin
      start_count++;
      if (!model_stuck) begin
        FIR_RDY   = 1'b0;
        busy_left = 10;
        model_din = FIR_DIN;
      end
    end else if (busy_left != 0) begin
      busy_left--;
      if (busy_left == 0) begin
        FIR_RDY  = 1'b1;
        FIR_DOUT = ~model_din;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer a sample, wait (bounded) for S_READY, complete the handshake.
  task automatic push(input logic [15:0] d);
    int unsigned n = 0;
    S_VALID = 1'b1;
    S_DATA  = d;
    while (!S_READY && n < 200) begin
      tick();
      n++;
    end
    check("push_ready", S_READY, 1'b1);
    tick();
    S_VALID = 1'b0;
  endtask

  // Wait (bounded) for a result and check it; consumption relies on M_READY.
  task automatic collect(input string name, input logic [15:0] exp);
    int unsigned n = 0;
    while (!M_VALID && n < 200) begin
      tick();
      n++;
    end
    check(name, {M_VALID, M_DATA}, {1'b1, exp});
    tick();
  endtask

  task automatic wait_level(input logic [2:0] lvl);
    int unsigned n = 0;
    while (FIFO_LEVEL != lvl && n < 100) begin
      tick();
      n++;
    end
  endtask

  typedef struct packed {
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [5];
  logic [15:0] bp_in  [6];
  logic [15:0] bp_out [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0;
    int unsigned lat;
    int unsigned spurious;
    int unsigned n;

    vecs[0] = '{din: 16'h0000, dout: 16'hFFFF};
    vecs[1] = '{din: 16'hFFFF, dout: 16'h0000};
    vecs[2] = '{din: 16'h8000, dout: 16'h7FFF};
    vecs[3] = '{din: 16'hA5A5, dout: 16'h5A5A};
    vecs[4] = '{din: 16'h0001, dout: 16'hFFFE};
    bp_in   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    bp_out  = '{16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999};

    nRST = 1'b0; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0; CLR_ERR = 1'b0;
    #2;
    check("rst_s_ready",   S_READY, 1'b0);
    check("rst_fir_start", FIR_START, 1'b0);
    check("rst_fir_din",   FIR_DIN, 16'h0);
    check("rst_m_valid",   M_VALID, 1'b0);
    check("rst_m_data",    M_DATA, 16'h0);
    check("rst_err",       TIMEOUT_ERR, 1'b0);
    check("rst_level",     FIFO_LEVEL, 3'd0);
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
    check("idle_s_ready", S_READY, 1'b1);

    // Single sample: start pulse right after accept, result 12 cycles after accept.
    M_READY = 1'b1;
    s0 = start_count;
    push(16'h1234);
    check("t1_start_pulse", FIR_START, 1'b1);
    check("t1_din", FIR_DIN, 16'h1234);
    tick();
    check("t1_start_low", FIR_START, 1'b0);
    lat = 2;
    while (!M_VALID && lat < 100) begin
      tick();
      lat++;
    end
    check("t1_latency", lat, 12);
    check("t1_data", M_DATA, 16'hEDCB);
    check("t1_din_held", FIR_DIN, 16'h1234);
    check("t1_start_count", start_count - s0, 1);
    tick();
    check("t1_valid_one_cycle", M_VALID, 1'b0);
    M_READY = 1'b0;

    // Table-driven single samples.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].din);
      wait_level(3'd1);
      check("vec_level", FIFO_LEVEL, 3'd1);
      check("vec_data", {M_VALID, M_DATA}, {1'b1, vecs[i].dout});
      check("vec_din", FIR_DIN, vecs[i].din);
      M_READY = 1'b1;
      tick();
      M_READY = 1'b0;
      check("vec_drained", M_VALID, 1'b0);
    end

    // Backpressure: four results fill the FIFO, fifth sample is refused.
    s0 = start_count;
    for (int i = 0; i < 4; i++) push(bp_in[i]);
    wait_level(3'd4);
    check("bp_level_full", FIFO_LEVEL, 3'd4);
    check("bp_head", M_DATA, bp_out[0]);
    S_VALID = 1'b1;
    S_DATA  = bp_in[4];
    repeat (30) tick();
    check("bp_s_ready_low", S_READY, 1'b0);
    check("bp_no_5th_start", start_count - s0, 4);
    S_VALID = 1'b0;
    fork
      begin
        push(bp_in[4]);
        push(bp_in[5]);
      end
      begin
        M_READY = 1'b1;
        for (int i = 0; i < 6; i++) collect("bp_order", bp_out[i]);
      end
    join
    M_READY = 1'b0;
    check("bp_start_total", start_count - s0, 6);
    check("bp_empty", FIFO_LEVEL, 3'd0);

    // Timeout: filter never drops RDY; 32 cycles in WAIT_* then abort.
    push(16'h0F0F);
    wait_level(3'd1);
    model_stuck = 1'b1;
    push(16'hBEEF);
    repeat (32) tick();
    check("to_err_not_yet", TIMEOUT_ERR, 1'b0);
    check("to_busy", S_READY, 1'b0);
    tick();
    check("to_err_set", TIMEOUT_ERR, 1'b1);
    check("to_s_ready", S_READY, 1'b1);
    check("to_level", FIFO_LEVEL, 3'd1);
    check("to_head", M_DATA, 16'hF0F0);
    model_stuck = 1'b0;
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("to_err_cleared", TIMEOUT_ERR, 1'b0);
    push(16'h00FF);
    wait_level(3'd2);
    check("to_next_level", FIFO_LEVEL, 3'd2);
    M_READY = 1'b1;
    collect("to_drain0", 16'hF0F0);
    collect("to_drain1", 16'hFF00);
    M_READY = 1'b0;

    // Simultaneous FIFO read and write at level 3, across a pointer wrap.
    push(16'h1357);
    push(16'h2468);
    push(16'h9ABC);
    wait_level(3'd3);
    check("rw_level3", FIFO_LEVEL, 3'd3);
    push(16'h0C0C);
    n = 0;
    while (FIR_RDY && n < 50) begin
      @(negedge CLK); #1;
      n++;
    end
    while (!FIR_RDY && n < 50) begin
      @(negedge CLK); #1;
      n++;
    end
    check("rw_head_before", M_DATA, 16'hECA8);
    M_READY = 1'b1;
    @(posedge CLK); #1;
    M_READY = 1'b0;
    check("rw_level_same", FIFO_LEVEL, 3'd3);
    M_READY = 1'b1;
    collect("rw_order1", 16'hDB97);
    collect("rw_order2", 16'h6543);
    collect("rw_order3", 16'hF3F3);
    M_READY = 1'b0;

    // Reset during WAIT_DONE with a result already queued.
    push(16'h4321);
    wait_level(3'd1);
    push(16'h7777);
    repeat (4) tick();
    nRST = 1'b0;
    #1;
    check("mr_fir_start", FIR_START, 1'b0);
    check("mr_fir_din",   FIR_DIN, 16'h0);
    check("mr_s_ready",   S_READY, 1'b0);
    check("mr_m_valid",   M_VALID, 1'b0);
    check("mr_m_data",    M_DATA, 16'h0);
    check("mr_err",       TIMEOUT_ERR, 1'b0);
    check("mr_level",     FIFO_LEVEL, 3'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b1;
    spurious = 0;
    repeat (20) begin
      tick();
      if (M_VALID) spurious++;
    end
    check("mr_no_spurious", spurious, 0);
    check("mr_level_after", FIFO_LEVEL, 3'd0);
    M_READY = 1'b1;
    push(16'h2040);
    collect("mr_next_sample", 16'hDFBF);
    M_READY = 1'b0;

    // S_DATA toggling while busy must not disturb FIR_DIN.
    s0 = start_count;
    push(16'hA5A5);
    S_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      S_DATA = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
      tick();
      check("tg_din_held", FIR_DIN, 16'hA5A5);
    end
    S_VALID = 1'b0;
    wait_level(3'd1);
    check("tg_result", {M_VALID, M_DATA}, {1'b1, 16'h5A5A});
    check("tg_din_after", FIR_DIN, 16'hA5A5);
    check("tg_one_start", start_count - s0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
